// File: rtl/flag_stack_register_pkg.sv
// Shared definitions for the flag register and its shadow stack.
package flag_stack_register_pkg;

    // Architectural flag bit positions
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    // Default sizing
    localparam int DEF_NUM_FLAGS   = 4;
    localparam int DEF_STACK_DEPTH = 4;

    // Width needed to count 0..d stack entries inclusive
    function automatic int depth_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/flag_stack_register_lifo.sv
// Shadow LIFO for flag save/restore: entry array, saturating depth counter,
// legality decode and the sticky misuse flag.
module flag_lifo
    import flag_stack_register_pkg::*;
#(
    parameter int NUM_FLAGS   = DEF_NUM_FLAGS,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic                                 err_clr,
    input  logic [NUM_FLAGS-1:0]                 push_data,
    output logic [NUM_FLAGS-1:0]                 pop_data,
    output logic                                 pop_ok,
    output logic [depth_w(STACK_DEPTH)-1:0]      depth,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 err
);

    localparam int DEPTH_W = depth_w(STACK_DEPTH);
    // Index width sized to the array so indexing is exact even for depth 1
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [NUM_FLAGS-1:0] mem [0:(1 << IDX_W)-1];
    logic [DEPTH_W-1:0]   depth_m1;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic                 push_ok;
    logic                 err_evt;

    assign full     = (depth == DEPTH_W'(STACK_DEPTH));
    assign empty    = (depth == '0);
    assign push_ok  = push & ~pop & ~full;
    assign pop_ok   = pop & ~push & ~empty;
    // Simultaneous push/pop, overflow and underflow are all misuse
    assign err_evt  = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
    assign depth_m1 = depth - DEPTH_W'(1);
    // Only consulted when the access is legal, so truncation never aliases
    assign wr_idx   = depth[IDX_W-1:0];
    assign rd_idx   = depth_m1[IDX_W-1:0];
    assign pop_data = mem[rd_idx];

    // Entry storage: written only on a legal push, contents not reset
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Depth counter saturates at both ends because only legal ops move it
    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
        end else if (push_ok) begin
            depth <= depth + DEPTH_W'(1);
        end else if (pop_ok) begin
            depth <= depth_m1;
        end
    end

    // Sticky error: a fresh error beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (err_evt) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: rtl/flag_stack_register.sv
// Status flag register with masked ALU load, software write and a shadow
// stack for interrupt entry/return and CALL/RET.
module flag_stack_register
    import flag_stack_register_pkg::*;
#(
    parameter int NUM_FLAGS   = DEF_NUM_FLAGS,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flag_load,
    input  logic [NUM_FLAGS-1:0]             flag_mask,
    input  logic [NUM_FLAGS-1:0]             flags_in,
    input  logic                             sw_write,
    input  logic [NUM_FLAGS-1:0]             sw_data,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             err_clr,
    output logic [NUM_FLAGS-1:0]             flags,
    output logic [depth_w(STACK_DEPTH)-1:0]  depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             stack_err
);

    logic [NUM_FLAGS-1:0] flags_next;
    logic [NUM_FLAGS-1:0] pop_data;
    logic                 pop_ok;

    // The stack always saves the registered (pre-update) flags
    flag_lifo #(
        .NUM_FLAGS   (NUM_FLAGS),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .push_data (flags),
        .pop_data  (pop_data),
        .pop_ok    (pop_ok),
        .depth     (depth),
        .full      (stack_full),
        .empty     (stack_empty),
        .err       (stack_err)
    );

    // Next-flag priority: restore, software write, masked ALU load, hold
    always_comb begin
        flags_next = flags;
        if (pop_ok) begin
            flags_next = pop_data;
        end else if (sw_write) begin
            flags_next = sw_data;
        end else if (flag_load) begin
            flags_next = (flags & ~flag_mask) | (flags_in & flag_mask);
        end
    end

    // Flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
        end else begin
            flags <= flags_next;
        end
    end

endmodule

// File: tb/tb_flag_stack_register.sv
// Directed scoreboard bench for flag_stack_register (defaults: 4 flags, depth 4).
module tb_flag_stack_register;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flag_load = 1'b0;
    logic [3:0] flag_mask = '0;
    logic [3:0] flags_in = '0;
    logic       sw_write = 1'b0;
    logic [3:0] sw_data = '0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] flags;
    logic [2:0] depth;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    typedef struct packed {
        logic [3:0] flags;
        logic [2:0] depth;
        logic       full;
        logic       empty;
        logic       err;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } sb_t;

    sb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    flag_stack_register dut (
        .clk         (clk),
        .reset       (reset),
        .flag_load   (flag_load),
        .flag_mask   (flag_mask),
        .flags_in    (flags_in),
        .sw_write    (sw_write),
        .sw_data     (sw_data),
        .push        (push),
        .pop         (pop),
        .err_clr     (err_clr),
        .flags       (flags),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus at the falling edge and queue what the
    // outputs must show after the next rising edge.
    task automatic step(input string nm,
                        input logic rs, input logic ld, input logic [3:0] msk,
                        input logic [3:0] fin, input logic sw, input logic [3:0] sd,
                        input logic ps, input logic pp, input logic ec,
                        input logic [3:0] ef, input logic [2:0] ed, input logic ee);
        sb_t e;
        @(negedge clk);
        reset = rs; flag_load = ld; flag_mask = msk; flags_in = fin;
        sw_write = sw; sw_data = sd; push = ps; pop = pp; err_clr = ec;
        e.name      = nm;
        e.exp.flags = ef;
        e.exp.depth = ed;
        e.exp.full  = (ed == 3'd4);
        e.exp.empty = (ed == 3'd0);
        e.exp.err   = ee;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, checked just after each edge
    initial begin
        sb_t  e;
        obs_t act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = '{flags, depth, stack_full, stack_empty, stack_err};
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got flags=%b depth=%0d full=%b empty=%b err=%b, expected flags=%b depth=%0d full=%b empty=%b err=%b",
                             e.name, act.flags, act.depth, act.full, act.empty, act.err,
                             e.exp.flags, e.exp.depth, e.exp.full, e.exp.empty, e.exp.err);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //    name          rst ld  mask     fin      sw  sdata    ps  pp  ec   flags    d     err
        step("reset",       1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0,   4'b0000, 3'd0, 0);
        step("load_mask03", 0, 1, 4'b0011, 4'b1111, 0, 4'b0000, 0, 0, 0,   4'b0011, 3'd0, 0);
        step("load_mask08", 0, 1, 4'b1000, 4'b0000, 0, 4'b0000, 0, 0, 0,   4'b0011, 3'd0, 0);
        step("sw_0101",     0, 0, 4'b0000, 4'b0000, 1, 4'b0101, 0, 0, 0,   4'b0101, 3'd0, 0);
        step("push_load",   0, 1, 4'b1111, 4'b1010, 0, 4'b0000, 1, 0, 0,   4'b1010, 3'd1, 0);
        step("pop_restore", 0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0,   4'b0101, 3'd0, 0);
        // Fill the stack with 1..4 (each push saves the pre-write value)
        step("sw_1",        0, 0, 4'b0000, 4'b0000, 1, 4'h1,    0, 0, 0,   4'h1,    3'd0, 0);
        step("push1_sw2",   0, 0, 4'b0000, 4'b0000, 1, 4'h2,    1, 0, 0,   4'h2,    3'd1, 0);
        step("push2_sw3",   0, 0, 4'b0000, 4'b0000, 1, 4'h3,    1, 0, 0,   4'h3,    3'd2, 0);
        step("push3_sw4",   0, 0, 4'b0000, 4'b0000, 1, 4'h4,    1, 0, 0,   4'h4,    3'd3, 0);
        step("push4_sw0",   0, 0, 4'b0000, 4'b0000, 1, 4'h0,    1, 0, 0,   4'h0,    3'd4, 0);
        step("push_full",   0, 0, 4'b0000, 4'b0000, 0, 4'h0,    1, 0, 0,   4'h0,    3'd4, 1);
        step("pop_4",       0, 0, 4'b0000, 4'b0000, 0, 4'h0,    0, 1, 0,   4'h4,    3'd3, 1);
        step("pop_3",       0, 0, 4'b0000, 4'b0000, 0, 4'h0,    0, 1, 0,   4'h3,    3'd2, 1);
        step("pop_2",       0, 0, 4'b0000, 4'b0000, 0, 4'h0,    0, 1, 0,   4'h2,    3'd1, 1);
        step("pop_1",       0, 0, 4'b0000, 4'b0000, 0, 4'h0,    0, 1, 0,   4'h1,    3'd0, 1);
        step("err_clr",     0, 0, 4'b0000, 4'b0000, 0, 4'h0,    0, 0, 1,   4'h1,    3'd0, 0);
        step("pop_empty_sw",0, 0, 4'b0000, 4'b0000, 1, 4'b1001, 0, 1, 0,   4'b1001, 3'd0, 1);
        step("err_clr2",    0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1,   4'b1001, 3'd0, 0);
        step("push_sw0110", 0, 0, 4'b0000, 4'b0000, 1, 4'b0110, 1, 0, 0,   4'b0110, 3'd1, 0);
        step("push_sw1110", 0, 0, 4'b0000, 4'b0000, 1, 4'b1110, 1, 0, 0,   4'b1110, 3'd2, 0);
        step("pushpop_load",0, 1, 4'b0001, 4'b0001, 0, 4'b0000, 1, 1, 0,   4'b1111, 3'd2, 1);
        step("pop_0110",    0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0,   4'b0110, 3'd1, 1);
        step("pop_over_sw", 0, 0, 4'b0000, 4'b0000, 1, 4'b0011, 0, 1, 1,   4'b1001, 3'd0, 0);
        step("clr_vs_err",  0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 1,   4'b1001, 3'd0, 1);
        step("sw_over_load",0, 1, 4'b1111, 4'b0011, 1, 4'b1100, 0, 0, 1,   4'b1100, 3'd0, 0);
        step("fill_a",      0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 0,   4'b1100, 3'd1, 0);
        step("fill_b",      0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 0,   4'b1100, 3'd2, 0);
        step("fill_c",      0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 0,   4'b1100, 3'd3, 0);
        step("reset_push",  1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1, 0, 0,   4'b0000, 3'd0, 0);
        step("pop_after_rst",0,0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0,   4'b0000, 3'd0, 1);
        step("idle",        0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0,   4'b0000, 3'd0, 1);

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flag_stack_register.md
Name: flag_stack_register

Overview:
- Parametrised successor to the two-bit carry/zero flag register.
- Holds NUM_FLAGS status flags with a per-bit ALU load mask and a direct software write path.
- Adds a LIFO shadow stack of STACK_DEPTH entries that saves and restores flags on interrupt entry/return and CALL/RET.
- Sits between the ALU flag outputs and the controller/branch unit.

Parameters:
- NUM_FLAGS, 4: number of flag bits (bit0 carry, bit1 zero, bit2 negative, bit3 overflow; extra bits user-defined).
- STACK_DEPTH, 4: number of shadow-stack entries; must be >= 1.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- flag_load  in  1  controller strobe: load ALU flags under mask
- flag_mask  in  NUM_FLAGS  per-bit load enable for flag_load (1 = update bit)
- flags_in  in  NUM_FLAGS  ALU flag outputs
- sw_write  in  1  controller strobe: overwrite all flags from sw_data
- sw_data  in  NUM_FLAGS  software flag value (e.g. POPF / move-to-status)
- push  in  1  save current flags to shadow stack
- pop  in  1  restore flags from shadow stack top
- err_clr  in  1  clears sticky stack_err
- flags  out  NUM_FLAGS  current flag register
- depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
- stack_full  out  1  depth == STACK_DEPTH
- stack_empty  out  1  depth == 0
- stack_err  out  1  sticky: illegal push/pop occurred

Behaviour:
- Reset (synchronous, active-high, clk edge): flags=0, depth=0, stack_err=0, stack entries don't-care. Reset overrides all other inputs in the same cycle.
- All outputs registered; an update is visible in the cycle after the strobe (1-cycle latency). stack_full/stack_empty are decoded from the registered depth.
- Next-flags priority, highest first:
  - (1) legal pop: flags <= stack top.
  - (2) sw_write: flags <= sw_data.
  - (3) flag_load: flags <= (flags & ~flag_mask) | (flags_in & flag_mask).
  - (4) hold.
- Lower-priority strobes in the same cycle are discarded, not deferred.
- Legal push (push & !pop & !stack_full): stack[depth] <= current registered flags (the pre-update value), depth+1. A flag_load or sw_write in the same cycle still updates flags; this is the interrupt-entry case.
- Legal pop (pop & !push & !stack_empty): flags <= stack[depth-1], depth-1.
- Push when full: stack and depth unchanged, stack_err <= 1. Flag sources (2)-(4) still apply.
- Pop when empty: depth unchanged, stack_err <= 1. Flags fall through to sources (2)-(4).
- push & pop in the same cycle: both ignored, stack_err <= 1. Flag sources (2)-(4) still apply.
- stack_err is sticky until err_clr. If err_clr and a new error occur in the same cycle, the error wins (stack_err=1).
- No wrap-around: depth saturates at 0 and STACK_DEPTH, and pointers never wrap.
- Reset mid-sequence discards all stacked entries; the next pop after reset is an underflow.

Decomposition:
- Shared package: flag bit index constants FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3; default NUM_FLAGS/STACK_DEPTH; a depth-width helper function.
- One natural sub-module, flag_lifo:
  - Register array plus depth counter, with push/pop/full/empty/err.
  - flag_stack_register instantiates it and holds the flag register and priority mux.

Test Plan:
- Reset, then flag_load=1, mask=4'b0011, flags_in=4'b1111 -> next cycle flags=4'b0011. Then mask=4'b1000, flags_in=0 -> flags stays 4'b0011.
- flags=4'b0101, push with flag_load mask=4'b1111 flags_in=4'b1010 in the same cycle -> flags=4'b1010, depth=1. Then pop -> flags=4'b0101, depth=0, stack_empty=1.
- Push 4 distinct values (4'h1..4'h4) with STACK_DEPTH=4 -> stack_full=1. Fifth push -> depth=4, stack_err=1. Four pops return 4'h4, 4'h3, 4'h2, 4'h1 in order.
- Pop on empty with sw_write=1, sw_data=4'b1001 in the same cycle -> flags=4'b1001, depth=0, stack_err=1. Then err_clr -> stack_err=0.
- push&pop together at depth=2 with flag_load mask=4'b0001 flags_in=4'b0001 -> depth=2, stack_err=1, only bit0 updated. pop & sw_write together at depth=1 -> popped value wins.
- Reset asserted at depth=3 with push=1 -> next cycle depth=0, flags=0, stack_err=0. Subsequent pop -> stack_err=1.
